hd63701_timer: RTL and testbench

- On-chip 16-bit programmable timer for the HD63701 core.
- Sits directly downstream of the core bus: it decodes AD/RW/DO, returns read data for the core's DI mux, and drives the core's IRQ2_TIM input.
- Provides:
  - free-running counter (FRC)
  - output compare (OCR) driving the TOUT pin
  - input capture (ICR) from the TIN pin
  - timer control/status register (TCSR)

---
 rtl/hd63701_timer.sv | 151 +++++++++++++++
 tb/tb_hd63701_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hd63701_timer.sv
// HD63701 on-chip 16-bit timer: free-running counter, output compare, input capture
// and TCSR, decoded straight off the core bus and interrupting through IRQ2_TIM.
module hd63701_timer #(
  parameter logic [15:0] BASE        = 16'h0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLKx2,
  input  logic        RSTn,
  input  logic        CE,
  input  logic [15:0] AD,
  input  logic        RW,
  input  logic [7:0]  DO,
  output logic [7:0]  RDATA,
  output logic        RSEL,
  input  logic        TIN,
  output logic        TOUT,
  output logic        IRQ2_TIM
);

  logic [15:0] r_frc, r_ocr, r_icr;
  logic [7:0]  r_rbuf, r_tmp;
  logic [4:0]  r_ctl;
  logic        r_icf, r_ocf, r_tof;
  logic        r_arm_icf, r_arm_ocf, r_arm_tof;
  logic [SYNC_STAGES-1:0] r_sync;
  logic        r_tin_d, r_cap_pend, r_tout, r_irq;

  logic [15:0] w_off;
  logic [2:0]  w_reg;
  logic        w_acc, w_rd, w_wr;
  logic        w_rd_tcsr, w_rd_frch, w_rd_icrh;
  logic        w_wr_tcsr, w_wr_frch, w_wr_frcl, w_wr_ocrh, w_wr_ocrl;
  logic        w_tin_s, w_edge, w_cap, w_wrap, w_ocmp;
  logic        w_clr_icf, w_clr_ocf, w_clr_tof;

  // Addresses below BASE wrap to large offsets, so one compare covers both ends.
  assign w_off = AD - BASE;
  assign RSEL  = (w_off <= 16'd6);
  assign w_reg = w_off[2:0];
  assign w_acc = RSEL & CE;
  assign w_rd  = w_acc & RW;
  assign w_wr  = w_acc & ~RW;

  assign w_rd_tcsr = w_rd & (w_reg == 3'd0);
  assign w_rd_frch = w_rd & (w_reg == 3'd1);
  assign w_rd_icrh = w_rd & (w_reg == 3'd5);
  assign w_wr_tcsr = w_wr & (w_reg == 3'd0);
  assign w_wr_frch = w_wr & (w_reg == 3'd1);
  assign w_wr_frcl = w_wr & (w_reg == 3'd2);
  assign w_wr_ocrh = w_wr & (w_reg == 3'd3);
  assign w_wr_ocrl = w_wr & (w_reg == 3'd4);

  assign w_tin_s = r_sync[SYNC_STAGES-1];
  assign w_edge  = r_ctl[1] ? (w_tin_s & ~r_tin_d) : (~w_tin_s & r_tin_d);
  // An edge seen on a non-CE cycle is held until the next CE cycle.
  assign w_cap   = CE & (w_edge | r_cap_pend);
  assign w_wrap  = CE & ~w_wr_frcl & (r_frc == 16'hFFFF);
  assign w_ocmp  = CE & ~(w_wr_ocrh | w_wr_ocrl) & (r_frc == r_ocr);

  assign w_clr_icf = w_rd_icrh & r_arm_icf;
  assign w_clr_ocf = (w_wr_ocrh | w_wr_ocrl) & r_arm_ocf;
  assign w_clr_tof = w_rd_frch & r_arm_tof;

  always_ff @(posedge CLKx2 or negedge RSTn) begin
    if (!RSTn) begin
      r_sync     <= '0;
      r_tin_d    <= 1'b0;
      r_cap_pend <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], TIN};
      r_tin_d    <= w_tin_s;
      r_cap_pend <= CE ? 1'b0 : (r_cap_pend | w_edge);
      r_irq      <= (r_icf & r_ctl[4]) | (r_ocf & r_ctl[3]) | (r_tof & r_ctl[2]);
    end
  end

  always_ff @(posedge CLKx2 or negedge RSTn) begin
    if (!RSTn) begin
      r_frc  <= 16'h0000;
      r_ocr  <= 16'hFFFF;
      r_icr  <= 16'h0000;
      r_rbuf <= 8'h00;
      r_tmp  <= 8'h00;
      r_ctl  <= 5'h00;
      r_tout <= 1'b0;
    end else if (CE) begin
      r_frc <= w_wr_frcl ? {r_tmp, DO} : r_frc + 16'd1;
      if (w_rd_frch) r_rbuf <= r_frc[7:0];
      if (w_wr_frch) r_tmp <= DO;
      if (w_wr_ocrh) r_ocr[15:8] <= DO;
      if (w_wr_ocrl) r_ocr[7:0] <= DO;
      if (w_wr_tcsr) r_ctl <= DO[4:0];
      if (w_cap) r_icr <= r_frc;
      if (w_ocmp) r_tout <= r_ctl[0];
    end
  end

  // Set beats clear; a clear also disarms, and a TCSR read arms only flags that are 1.
  always_ff @(posedge CLKx2 or negedge RSTn) begin
    if (!RSTn) begin
      r_icf     <= 1'b0;
      r_ocf     <= 1'b0;
      r_tof     <= 1'b0;
      r_arm_icf <= 1'b0;
      r_arm_ocf <= 1'b0;
      r_arm_tof <= 1'b0;
    end else begin
      if (w_cap) r_icf <= 1'b1;
      else if (w_clr_icf) begin
        r_icf     <= 1'b0;
        r_arm_icf <= 1'b0;
      end
      if (w_ocmp) r_ocf <= 1'b1;
      else if (w_clr_ocf) begin
        r_ocf     <= 1'b0;
        r_arm_ocf <= 1'b0;
      end
      if (w_wrap) r_tof <= 1'b1;
      else if (w_clr_tof) begin
        r_tof     <= 1'b0;
        r_arm_tof <= 1'b0;
      end
      if (w_rd_tcsr) begin
        r_arm_icf <= r_icf;
        r_arm_ocf <= r_ocf;
        r_arm_tof <= r_tof;
      end
    end
  end

  always_comb begin
    RDATA = 8'h00;
    if (RSEL) begin
      case (w_reg)
        3'd0:    RDATA = {r_icf, r_ocf, r_tof, r_ctl};
        3'd1:    RDATA = r_frc[15:8];
        3'd2:    RDATA = r_rbuf;
        3'd3:    RDATA = r_ocr[15:8];
        3'd4:    RDATA = r_ocr[7:0];
        3'd5:    RDATA = r_icr[15:8];
        3'd6:    RDATA = r_icr[7:0];
        default: RDATA = 8'h00;
      endcase
    end
  end

  assign TOUT     = r_tout;
  assign IRQ2_TIM = r_irq;

endmodule

// File: tb/tb_hd63701_timer.sv
// Scoreboard bench for hd63701_timer: directed bus cycles push hand-computed
// expectations; a monitor pops and compares on every read strobe or pin probe.
module tb_hd63701_timer;

  logic        CLKx2, RSTn, CE, RW, TIN;
  logic [15:0] AD;
  logic [7:0]  DO, RDATA;
  logic        RSEL, TOUT, IRQ2_TIM;

  hd63701_timer #(.BASE(16'h0008), .SYNC_STAGES(2)) dut (
    .CLKx2(CLKx2), .RSTn(RSTn), .CE(CE), .AD(AD), .RW(RW), .DO(DO),
    .RDATA(RDATA), .RSEL(RSEL), .TIN(TIN), .TOUT(TOUT), .IRQ2_TIM(IRQ2_TIM)
  );

  typedef struct {
    string       name;
    bit          kind;   // 0: {RSEL,RDATA} on a read, 1: {TOUT,IRQ2_TIM} probe
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  rd_stb   = 1'b0;
  logic  probe    = 1'b0;

  initial CLKx2 = 1'b0;
  always #5 CLKx2 = ~CLKx2;

  // Monitor: samples 3 time units after the falling edge, well away from posedge.
  always @(negedge CLKx2) begin
    item_t       it;
    logic [15:0] act;
    #3;
    if (rd_stb || probe) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got output with no expectation queued");
      end else begin
        it  = sb.pop_front();
        act = it.kind ? {14'h0, TOUT, IRQ2_TIM} : {7'h0, RSEL, RDATA};
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    sb.push_back('{nm, 1'b0, exp});
    @(negedge CLKx2);
    CE = 1'b1; AD = a; RW = 1'b1; DO = 8'h00; rd_stb = 1'b1;
    @(negedge CLKx2);
    CE = 1'b0; AD = 16'h0000; rd_stb = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLKx2);
    CE = 1'b1; AD = a; RW = 1'b0; DO = d;
    @(negedge CLKx2);
    CE = 1'b0; AD = 16'h0000; RW = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLKx2);
      CE = 1'b1;
      @(negedge CLKx2);
      CE = 1'b0;
    end
  endtask

  // Samples the pins now (state after the most recent edge), then lets one CLKx2 pass.
  task automatic pins(input logic [15:0] exp, input string nm);
    sb.push_back('{nm, 1'b1, exp});
    probe = 1'b1;
    @(negedge CLKx2);
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; CE = 1'b0; AD = 16'h0000; RW = 1'b1; DO = 8'h00; TIN = 1'b0;
    repeat (3) @(negedge CLKx2);
    RSTn = 1'b1;

    // Reset state and coherent FRC read
    pins(16'h0000, "rst_pins");
    idle(3);
    rd(16'h0009, 16'h0100, "frch_after_reset");
    rd(16'h000A, 16'h0103, "frcl_latched");
    rd(16'h0008, 16'h0100, "tcsr_reset");
    rd(16'h000B, 16'h01FF, "ocrh_reset");
    rd(16'h000C, 16'h01FF, "ocrl_reset");
    rd(16'h000D, 16'h0100, "icrh_reset");
    rd(16'h000E, 16'h0100, "icrl_reset");
    rd(16'h000F, 16'h0000, "above_range");
    rd(16'h0007, 16'h0000, "below_range");
    pins(16'h0000, "pins_idle");

    // Overflow, TOF and its two-step clear
    wr(16'h000B, 8'h80);
    wr(16'h000C, 8'h00);
    wr(16'h0008, 8'h04);
    wr(16'h0009, 8'hFF);
    wr(16'h000A, 8'hFE);
    idle(1);
    pins(16'h0000, "pre_wrap_irq");
    idle(1);
    pins(16'h0000, "irq_lag");
    pins(16'h0001, "irq_tof");
    rd(16'h0008, 16'h0124, "tcsr_tof");
    rd(16'h0009, 16'h0100, "frch_clear_tof");
    pins(16'h0001, "irq_fall_lag");
    pins(16'h0000, "irq_fall");
    rd(16'h0008, 16'h0104, "tcsr_tof_clr");

    // Output compare
    wr(16'h0008, 8'h09);
    wr(16'h000B, 8'h00);
    wr(16'h000C, 8'h10);
    wr(16'h0009, 8'h00);
    wr(16'h000A, 8'h0C);
    idle(4);
    pins(16'h0000, "tout_before_match");
    idle(1);
    pins(16'h0002, "tout_match");
    pins(16'h0003, "irq_ocf");
    rd(16'h0008, 16'h0149, "tcsr_ocf");
    wr(16'h000C, 8'h80);
    rd(16'h0008, 16'h0109, "tcsr_ocf_clr");
    pins(16'h0002, "irq_ocf_clr");
    // Compare suppressed when OCR is written in the matching cycle
    wr(16'h0008, 8'h08);
    wr(16'h0009, 8'h00);
    wr(16'h000A, 8'h7F);
    idle(1);
    wr(16'h000C, 8'h80);
    pins(16'h0002, "ocmp_suppressed_tout");
    rd(16'h0008, 16'h0108, "ocmp_suppressed_ocf");

    // Input capture
    wr(16'h0008, 8'h12);
    TIN = 1'b1;
    idle(3);
    pins(16'h0003, "irq_icf");
    rd(16'h0008, 16'h0192, "tcsr_icf");
    rd(16'h000D, 16'h0100, "icrh_capture");
    rd(16'h000E, 16'h0184, "icrl_capture");
    rd(16'h0008, 16'h0112, "tcsr_icf_clr");
    TIN = 1'b0;
    idle(3);
    rd(16'h0008, 16'h0112, "no_capture_fall");
    rd(16'h000E, 16'h0184, "icr_unchanged");
    wr(16'h0008, 8'h10);
    TIN = 1'b1;
    idle(3);
    TIN = 1'b0;
    idle(3);
    rd(16'h000E, 16'h0194, "icrl_falling");
    rd(16'h0008, 16'h0190, "tcsr_icf_fall");
    rd(16'h000D, 16'h0100, "icrh_clear2");

    // Set/clear race on TOF
    wr(16'h0008, 8'h04);
    wr(16'h0009, 8'hFF);
    wr(16'h000A, 8'hFE);
    idle(2);
    rd(16'h0008, 16'h0124, "race_tcsr_arm");
    wr(16'h0009, 8'hFF);
    wr(16'h000A, 8'hFF);
    rd(16'h0009, 16'h01FF, "race_frch");
    pins(16'h0003, "race_irq_a");
    pins(16'h0003, "race_tof_kept");
    rd(16'h000A, 16'h01FF, "race_frcl");
    rd(16'h0009, 16'h0100, "race_second_frch");
    pins(16'h0003, "race_irq_lag");
    pins(16'h0002, "race_tof_cleared");
    rd(16'h0008, 16'h0104, "race_tcsr");

    // Asynchronous reset mid-operation
    wr(16'h0008, 8'h09);
    wr(16'h000B, 8'h00);
    wr(16'h000C, 8'h07);
    idle(2);
    pins(16'h0002, "pre_reset_tout");
    pins(16'h0003, "pre_reset_irq");
    RSTn = 1'b0;
    pins(16'h0000, "async_reset_pins");
    rd(16'h0008, 16'h0100, "reset_tcsr");
    rd(16'h000B, 16'h01FF, "reset_ocrh");
    rd(16'h0009, 16'h0100, "reset_frch");
    RSTn = 1'b1;
    idle(2);
    rd(16'h0009, 16'h0100, "resume_frch");
    rd(16'h000A, 16'h0102, "resume_frcl");
    rd(16'h0008, 16'h0100, "resume_tcsr");
    pins(16'h0000, "resume_pins");

    repeat (4) @(negedge CLKx2);
    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: no response observed, expected %h", it.name, it.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
